ksa_pipelined_addsub: RTL and testbench

Parametrised, pipelined Kogge-Stone adder/subtractor. It is the successor to the fixed 32-bit combinational prefix adder. Operand width and pipeline-register spacing are configurable. It adds a subtract mode, signed-overflow and zero flags, a pass-through tag, and a valid/ready stream interface with full-pipeline stall. It sits between operand issue logic and any consumer that requires registered results.

---
 rtl/ksa_pkg.sv | 20 ++
 rtl/ksa_prefix_level.sv | 23 ++
 rtl/ksa_pipelined_addsub.sv | 155 +++++++++++++++
 tb/tb_ksa_pipelined_addsub.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ksa_pkg.sv
// Shared helpers for the pipelined Kogge-Stone adder/subtractor:
// prefix-depth and latency arithmetic used to size the pipeline.
package ksa_pkg;

  localparam int KSA_MAX_WIDTH = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Rank 0 + one register per REG_EVERY prefix levels + output rank
  function automatic int ksa_latency(input int width, input int reg_every);
    return 2 + (clog2(width) + reg_every - 1) / reg_every;
  endfunction

endpackage

// File: rtl/ksa_prefix_level.sv
// One Kogge-Stone prefix row: black cells at bit i >= SPAN, pass-through
// below. Purely combinational.
module ksa_prefix_level #(
  parameter int WIDTH = 32,
  parameter int SPAN  = 1
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i >= SPAN) begin : g_cell
      assign g_out[i] = g_in[i] | (p_in[i] & g_in[i-SPAN]);
      assign p_out[i] = p_in[i] & p_in[i-SPAN];
    end else begin : g_pass
      assign g_out[i] = g_in[i];
      assign p_out[i] = p_in[i];
    end
  end

endmodule

// File: rtl/ksa_pipelined_addsub.sv
// Pipelined Kogge-Stone add/subtract with flags, sideband tag and a
// valid/ready stream interface; the whole pipe stalls as one unit.
module ksa_pipelined_addsub
  import ksa_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NLVL   = clog2(WIDTH);
  localparam int LAT    = ksa_latency(WIDTH, REG_EVERY);
  localparam int STAGES = LAT - 1;     // vld_pipe[0] = rank 0, [STAGES] = output
  localparam int NRANK  = STAGES - 1;  // registered prefix ranks

  if (WIDTH < 4 || WIDTH > KSA_MAX_WIDTH || REG_EVERY < 1 || REG_EVERY > NLVL)
  begin : g_param_err
    $error("ksa_pipelined_addsub: illegal WIDTH/REG_EVERY");
  end

  logic [STAGES:0] vld_pipe;
  logic            advance;

  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
  end

  // Operand prep; carry-in folded into bit 0 generate
  logic [WIDTH-1:0] b_eff, g_in, p_in;
  logic             c0;

  always_comb begin
    b_eff   = in_sub ? ~in_b : in_b;
    c0      = in_sub | in_cin;
    p_in    = in_a ^ b_eff;
    g_in    = in_a & b_eff;
    g_in[0] = g_in[0] | (p_in[0] & c0);
  end

  // Rank storage; the last rank needs no group-propagate
  logic [WIDTH-1:0] g_d   [NRANK+1];
  logic [WIDTH-1:0] g_q   [NRANK+1];
  logic [WIDTH-1:0] p_d   [NRANK];
  logic [WIDTH-1:0] p_q   [NRANK];
  logic [WIDTH-1:0] po_q  [NRANK+1];
  logic             c0_q  [NRANK+1];
  logic [TAG_W-1:0] tag_q [NRANK+1];

  assign g_d[0] = g_in;
  assign p_d[0] = p_in;

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int r = 0; r <= NRANK; r++) g_q[r] <= g_d[r];
      for (int r = 0; r < NRANK; r++)  p_q[r] <= p_d[r];
      po_q[0]  <= p_in;
      c0_q[0]  <= c0;
      tag_q[0] <= in_tag;
      for (int r = 1; r <= NRANK; r++) begin
        po_q[r]  <= po_q[r-1];
        c0_q[r]  <= c0_q[r-1];
        tag_q[r] <= tag_q[r-1];
      end
    end
  end

  // Prefix tree: lvl_* is the level output after its optional register
  logic [WIDTH-1:0] lvl_g [NLVL+1];
  logic [WIDTH-1:0] lvl_p [NLVL];

  assign lvl_g[0] = g_q[0];
  assign lvl_p[0] = p_q[0];

  for (genvar k = 1; k <= NLVL; k++) begin : g_lvl
    localparam bit REG = (k % REG_EVERY == 0) || (k == NLVL);
    logic [WIDTH-1:0] g_o, p_o;

    ksa_prefix_level #(
      .WIDTH (WIDTH),
      .SPAN  (1 << (k-1))
    ) u_lvl (
      .g_in  (lvl_g[k-1]),
      .p_in  (lvl_p[k-1]),
      .g_out (g_o),
      .p_out (p_o)
    );

    if (REG) begin : g_greg
      localparam int R = (k + REG_EVERY - 1) / REG_EVERY;
      assign g_d[R]   = g_o;
      assign lvl_g[k] = g_q[R];
    end else begin : g_gcomb
      assign lvl_g[k] = g_o;
    end

    if (k < NLVL) begin : g_pnext
      if (REG) begin : g_preg
        localparam int R = k / REG_EVERY;
        assign p_d[R]   = p_o;
        assign lvl_p[k] = p_q[R];
      end else begin : g_pcomb
        assign lvl_p[k] = p_o;
      end
    end else begin : g_plast
      logic p_unused;
      assign p_unused = ^p_o;
    end
  end

  // Final rank: carries from the completed group generates
  logic [WIDTH-1:0] g_f, carry, sum_c;

  assign g_f   = g_q[NRANK];
  assign carry = {g_f[WIDTH-2:0], c0_q[NRANK]};
  assign sum_c = po_q[NRANK] ^ carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
      out_tag  <= '0;
    end else if (advance) begin
      out_sum  <= sum_c;
      out_cout <= g_f[WIDTH-1];
      out_ovf  <= carry[WIDTH-1] ^ g_f[WIDTH-1];
      out_zero <= ~|sum_c;
      out_tag  <= tag_q[NRANK];
    end
  end

endmodule

// File: tb/tb_ksa_pipelined_addsub.sv
// Randomised and directed checks of the pipelined add/sub against a plain
// arithmetic reference model; 32-bit/REG_EVERY=1 and 8-bit/REG_EVERY=2.
module tb_ksa_pipelined_addsub;

  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  logic        v32 = 0, or32 = 1, cin32 = 0, sub32 = 0;
  logic        rdy32, ov32, co32, ovf32, z32;
  logic [31:0] a32 = 0, b32 = 0, sum32;
  logic [3:0]  tag32 = 0, otag32;

  logic        v8 = 0, or8 = 1, cin8 = 0, sub8 = 0;
  logic        rdy8, ov8, co8, ovf8, z8;
  logic [7:0]  a8 = 0, b8 = 0, sum8;
  logic [3:0]  tag8 = 0, otag8;

  ksa_pipelined_addsub #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(rdy32),
    .in_a(a32), .in_b(b32), .in_cin(cin32), .in_sub(sub32), .in_tag(tag32),
    .out_valid(ov32), .out_ready(or32), .out_sum(sum32), .out_cout(co32),
    .out_ovf(ovf32), .out_zero(z32), .out_tag(otag32));

  ksa_pipelined_addsub #(.WIDTH(8), .REG_EVERY(2), .TAG_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8),
    .in_a(a8), .in_b(b8), .in_cin(cin8), .in_sub(sub8), .in_tag(tag8),
    .out_valid(ov8), .out_ready(or8), .out_sum(sum8), .out_cout(co8),
    .out_ovf(ovf8), .out_zero(z8), .out_tag(otag8));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  // Reference: plain wide arithmetic on the two's-complement operands
  function automatic res_t ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic cin, input logic sub);
    logic [64:0] full, mask;
    logic [63:0] am, be;
    res_t r;
    mask   = (65'd1 << w) - 65'd1;
    am     = a & mask[63:0];
    be     = (sub ? ~b : b) & mask[63:0];
    full   = {1'b0, am} + {1'b0, be} + {64'd0, (sub ? 1'b1 : cin)};
    r.sum  = full[63:0] & mask[63:0];
    r.cout = full[w];
    r.ovf  = (am[w-1] == be[w-1]) && (r.sum[w-1] != am[w-1]);
    r.zero = (r.sum == 64'd0);
    return r;
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Call at posedge+1 with the pipe empty; returns edges until out_valid
  task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input logic [3:0] tag, output int lat);
    a32 = a; b32 = b; cin32 = cin; sub32 = sub; tag32 = tag; v32 = 1; lat = 0;
    do begin @(posedge clk); #1; v32 = 0; lat++; end while (!ov32 && lat < 40);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic sub, input logic [3:0] tag, output int lat);
    a8 = a; b8 = b; cin8 = cin; sub8 = sub; tag8 = tag; v8 = 1; lat = 0;
    do begin @(posedge clk); #1; v8 = 0; lat++; end while (!ov8 && lat < 40);
  endtask

  typedef struct packed {
    logic [31:0] a, b;
    logic        cin, sub;
    logic [31:0] sum;
    logic        cout, ovf, zero;
  } dir_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout, ovf, zero;
    logic [3:0]  tag;
  } exp32_t;

  dir_t        dirs [6];
  exp32_t      q32 [$];
  logic [15:0] q8 [$];
  int          lat, acc, popped, stale, pushed8, popped8;

  initial begin
    dirs = '{
      '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1},
      '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0},
      '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0},
      '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0},
      '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0},
      '{32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 32'h2222_2222, 1'b0, 1'b0, 1'b0}};

    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid32", ov32, 0);
    chk("rst_ready32", rdy32, 1);
    chk("rst_out32", {sum32, co32, ovf32, z32, otag32}, 0);
    chk("rst_valid8", ov8, 0);
    chk("rst_out8", {sum8, co8, ovf8, z8, otag8}, 0);
    rst_n = 1;
    @(posedge clk); #1;

    foreach (dirs[i]) begin
      issue32(dirs[i].a, dirs[i].b, dirs[i].cin, dirs[i].sub, 4'(i), lat);
      chk("d_lat", lat, 7);
      chk("d_sum", sum32, dirs[i].sum);
      chk("d_cout", co32, dirs[i].cout);
      chk("d_ovf", ovf32, dirs[i].ovf);
      chk("d_zero", z32, dirs[i].zero);
      chk("d_tag", otag32, 4'(i));
    end

    issue8(8'hFF, 8'h01, 1'b0, 1'b0, 4'h9, lat);
    chk("w8_lat", lat, 4);
    chk("w8_out", {sum8, co8, ovf8, z8, otag8}, {8'h00, 1'b1, 1'b0, 1'b1, 4'h9});
    @(posedge clk); #1;

    // Random stream with out_ready low every third cycle
    acc = 0; popped = 0;
    fork
      begin
        int guard = 0;
        while (acc < 100 && guard < 2000) begin
          @(posedge clk); #1; guard++;
          v32 = ($urandom_range(0, 4) != 0);
          a32 = pick32(); b32 = pick32();
          cin32 = 1'($urandom_range(0, 1)); sub32 = 1'($urandom_range(0, 1));
          tag32 = 4'(acc);
          @(negedge clk);
          if (v32 && rdy32) begin
            res_t r;
            r = ref_op(32, {32'd0, a32}, {32'd0, b32}, cin32, sub32);
            q32.push_back('{r.sum[31:0], r.cout, r.ovf, r.zero, tag32});
            acc++;
          end
        end
        @(posedge clk); #1; v32 = 0;
      end
      begin
        int mcyc = 0;
        logic stalled = 0;
        logic [39:0] hold = '0;
        while (popped < 100 && mcyc < 3000) begin
          @(posedge clk); #1; mcyc++;
          or32 = (mcyc % 3 != 0);
          @(negedge clk);
          if (stalled) chk("s32_hold", {ov32, sum32, co32, ovf32, z32, otag32}, hold);
          stalled = ov32 && !or32;
          hold = {ov32, sum32, co32, ovf32, z32, otag32};
          if (ov32 && or32) begin
            if (q32.size() == 0) chk("s32_unexp", ov32, 0);
            else begin
              exp32_t e;
              e = q32.pop_front();
              chk("s32_sum", sum32, e.sum);
              chk("s32_flags", {co32, ovf32, z32}, {e.cout, e.ovf, e.zero});
              chk("s32_tag", otag32, e.tag);
              popped++;
            end
          end
        end
        @(posedge clk); #1; or32 = 1;
      end
    join
    chk("s32_count", popped, 100);
    chk("s32_left", q32.size(), 0);

    // Fill all seven ranks, then reset mid-stream
    repeat (10) @(posedge clk);
    #1; or32 = 0;
    for (int i = 0; i < 7; i++) begin
      a32 = $urandom; b32 = $urandom; tag32 = 4'(i); v32 = 1;
      @(posedge clk); #1;
    end
    v32 = 0;
    chk("fill_valid", ov32, 1);
    chk("fill_ready", rdy32, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_valid", ov32, 0);
    chk("mid_rst_sum", sum32, 0);
    @(posedge clk); #1;
    rst_n = 1; or32 = 1;
    stale = 0;
    repeat (12) begin @(negedge clk); if (ov32) stale++; end
    chk("no_stale", stale, 0);

    // All 8-bit operand pairs, random add/sub and carry-in, full rate
    pushed8 = 0; popped8 = 0;
    fork
      begin
        for (int a = 0; a < 256; a++)
          for (int b = 0; b < 256; b++) begin
            @(posedge clk); #1;
            a8 = 8'(a); b8 = 8'(b); tag8 = 4'(b);
            sub8 = 1'($urandom_range(0, 1)); cin8 = 1'($urandom_range(0, 1)); v8 = 1;
            @(negedge clk);
            if (rdy8) begin
              res_t r;
              r = ref_op(8, {56'd0, a8}, {56'd0, b8}, cin8, sub8);
              q8.push_back({r.sum[7:0], r.cout, r.ovf, r.zero, tag8});
              pushed8++;
            end
          end
        @(posedge clk); #1; v8 = 0;
      end
      begin
        int guard = 0;
        while (popped8 < 65536 && guard < 70000) begin
          @(negedge clk); guard++;
          if (ov8) begin
            if (q8.size() == 0) chk("x8_unexp", ov8, 0);
            else begin
              chk("x8_res", {sum8, co8, ovf8, z8, otag8}, q8.pop_front());
              popped8++;
            end
          end
        end
      end
    join
    chk("x8_pushed", pushed8, 65536);
    chk("x8_popped", popped8, 65536);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
